// File: rtl/vga_pkg.sv
// Shared 800x600@60 raster constants and the count type used by every stage
// of the video pipeline.
package vga_pkg;

    localparam int COUNT_W = 11;
    typedef logic [COUNT_W-1:0] count_t;

    localparam int H_ACTIVE = 800;
    localparam int H_FP     = 40;
    localparam int H_SYNC   = 128;
    localparam int H_BP     = 88;
    localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;

    localparam int V_ACTIVE = 600;
    localparam int V_FP     = 1;
    localparam int V_SYNC   = 4;
    localparam int V_BP     = 23;
    localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam bit SYNC_POL = 1'b1;

    // Last visible column/row, used by the drawing stages for border edges.
    localparam count_t H_LAST_VISIBLE = count_t'(H_ACTIVE - 1);
    localparam count_t V_LAST_VISIBLE = count_t'(V_ACTIVE - 1);

endpackage

// File: rtl/vga_axis_counter.sv
// One raster axis: wrapping counter plus registered blank/sync decode taken
// from the next-state count, so strobes line up with the count they describe.
module vga_axis_counter
    import vga_pkg::*;
#(
    parameter int ACTIVE     = 800,
    parameter int FP         = 40,
    parameter int SYNC       = 128,
    parameter int BP         = 88,
    parameter bit SYNC_LEVEL = 1'b1
) (
    input  logic   pclk,
    input  logic   rst_n,
    input  logic   inc,
    output count_t count,
    output logic   blnk,
    output logic   sync,
    output logic   wrap
);

    localparam int     TOTAL      = ACTIVE + FP + SYNC + BP;
    localparam count_t LAST       = count_t'(TOTAL - 1);
    localparam count_t BLNK_FIRST = count_t'(ACTIVE);
    localparam count_t SYNC_FIRST = count_t'(ACTIVE + FP);
    localparam count_t SYNC_LAST  = count_t'(ACTIVE + FP + SYNC - 1);

    if (TOTAL > 2048 || TOTAL < 2) begin : g_total_check
        $error("vga_axis_counter: total %0d does not fit an 11-bit count", TOTAL);
    end

    logic   terminal;
    count_t count_nxt;

    // ">=" rather than "==" so a corrupted out-of-range count recovers.
    always_comb begin
        terminal  = (count >= LAST);
        wrap      = inc && terminal;
        count_nxt = count;
        if (inc) begin
            count_nxt = terminal ? '0 : count + count_t'(1);
        end
    end

    always_ff @(posedge pclk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
            blnk  <= 1'b0;
            sync  <= !SYNC_LEVEL;
        end else begin
            count <= count_nxt;
            blnk  <= (count_nxt >= BLNK_FIRST);
            sync  <= (count_nxt >= SYNC_FIRST && count_nxt <= SYNC_LAST) ?
                     SYNC_LEVEL : !SYNC_LEVEL;
        end
    end

endmodule

// File: rtl/vga_timing.sv
// VGA raster timing generator: horizontal counter chained into a vertical
// counter, with a registered frame_start on the combined wrap to (0,0).
module vga_timing
    import vga_pkg::*;
#(
    parameter int H_ACT      = H_ACTIVE,
    parameter int H_FRONT    = H_FP,
    parameter int H_PULSE    = H_SYNC,
    parameter int H_BACK     = H_BP,
    parameter int V_ACT      = V_ACTIVE,
    parameter int V_FRONT    = V_FP,
    parameter int V_PULSE    = V_SYNC,
    parameter int V_BACK     = V_BP,
    parameter bit SYNC_LEVEL = SYNC_POL
) (
    input  logic               pclk,
    input  logic               rst_n,
    output logic [COUNT_W-1:0] hcount,
    output logic               hsync,
    output logic               hblnk,
    output logic [COUNT_W-1:0] vcount,
    output logic               vsync,
    output logic               vblnk,
    output logic               frame_start
);

    logic h_wrap;
    logic v_wrap;

    vga_axis_counter #(
        .ACTIVE     (H_ACT),
        .FP         (H_FRONT),
        .SYNC       (H_PULSE),
        .BP         (H_BACK),
        .SYNC_LEVEL (SYNC_LEVEL)
    ) u_h_axis (
        .pclk  (pclk),
        .rst_n (rst_n),
        .inc   (1'b1),
        .count (hcount),
        .blnk  (hblnk),
        .sync  (hsync),
        .wrap  (h_wrap)
    );

    // The vertical axis advances only on the cycle the line wraps.
    vga_axis_counter #(
        .ACTIVE     (V_ACT),
        .FP         (V_FRONT),
        .SYNC       (V_PULSE),
        .BP         (V_BACK),
        .SYNC_LEVEL (SYNC_LEVEL)
    ) u_v_axis (
        .pclk  (pclk),
        .rst_n (rst_n),
        .inc   (h_wrap),
        .count (vcount),
        .blnk  (vblnk),
        .sync  (vsync),
        .wrap  (v_wrap)
    );

    // Registered on the same edge the counters land on (0,0); the reset
    // state (0,0) therefore never raises it.
    always_ff @(posedge pclk or negedge rst_n) begin
        if (!rst_n) begin
            frame_start <= 1'b0;
        end else begin
            frame_start <= h_wrap && v_wrap;
        end
    end

endmodule

// File: tb/tb_vga_timing.sv
// Bench for vga_timing: full 800x600 instance plus two shrunken-raster
// instances (both sync polarities) against a cycle-count reference model.
`timescale 1ns/100ps
module tb_vga_timing;

    // Shrunken raster so several whole frames fit in a short run.
    localparam int SH_A = 16, SH_F = 2, SH_S = 4, SH_B = 3;
    localparam int SV_A = 10, SV_F = 1, SV_S = 2, SV_B = 3;
    localparam int S_FRAME = (SH_A + SH_F + SH_S + SH_B) * (SV_A + SV_F + SV_S + SV_B);

    logic        pclk = 1'b0;
    logic        rst_n = 1'b0;

    logic [10:0] f_hcount, f_vcount, n_hcount, n_vcount, p_hcount, p_vcount;
    logic        f_hsync, f_hblnk, f_vsync, f_vblnk, f_fs;
    logic        n_hsync, n_hblnk, n_vsync, n_vblnk, n_fs;
    logic        p_hsync, p_hblnk, p_vsync, p_vblnk, p_fs;

    int          n_checks = 0;
    int          n_fail = 0;
    longint      t_cyc = 0;
    logic [31:0] exp_q[$];

    // ---------------- clock ----------------
    always #12.5 pclk = ~pclk;

    // ---------------- DUTs ----------------
    vga_timing u_full (
        .pclk (pclk), .rst_n (rst_n),
        .hcount (f_hcount), .hsync (f_hsync), .hblnk (f_hblnk),
        .vcount (f_vcount), .vsync (f_vsync), .vblnk (f_vblnk),
        .frame_start (f_fs)
    );

    vga_timing #(
        .H_ACT (SH_A), .H_FRONT (SH_F), .H_PULSE (SH_S), .H_BACK (SH_B),
        .V_ACT (SV_A), .V_FRONT (SV_F), .V_PULSE (SV_S), .V_BACK (SV_B),
        .SYNC_LEVEL (1'b0)
    ) u_small_n (
        .pclk (pclk), .rst_n (rst_n),
        .hcount (n_hcount), .hsync (n_hsync), .hblnk (n_hblnk),
        .vcount (n_vcount), .vsync (n_vsync), .vblnk (n_vblnk),
        .frame_start (n_fs)
    );

    vga_timing #(
        .H_ACT (SH_A), .H_FRONT (SH_F), .H_PULSE (SH_S), .H_BACK (SH_B),
        .V_ACT (SV_A), .V_FRONT (SV_F), .V_PULSE (SV_S), .V_BACK (SV_B),
        .SYNC_LEVEL (1'b1)
    ) u_small_p (
        .pclk (pclk), .rst_n (rst_n),
        .hcount (p_hcount), .hsync (p_hsync), .hblnk (p_hblnk),
        .vcount (p_vcount), .vsync (p_vsync), .vblnk (p_vblnk),
        .frame_start (p_fs)
    );

    // ---------------- checking ----------------
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            if (n_fail <= 40)
                $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, exp, t_cyc);
        end
    endtask

    // Reference: position follows directly from cycles elapsed since reset
    // release; t=0 is both the reset state and pixel (0,0) without a pulse.
    task automatic check_dut(input string name,
                             input int ha, input int hf, input int hs, input int hbp,
                             input int va, input int vf, input int vs, input int vbp,
                             input bit pol, input longint t,
                             input logic [10:0] hc, input logic [10:0] vc,
                             input logic hbl, input logic hsy,
                             input logic vbl, input logic vsy, input logic fs);
        int ht, vt, h, v;
        bit e_hs, e_vs, e_fs;
        ht   = ha + hf + hs + hbp;
        vt   = va + vf + vs + vbp;
        h    = int'(t % ht);
        v    = int'((t / ht) % vt);
        e_hs = (h >= ha + hf && h < ha + hf + hs) ? pol : !pol;
        e_vs = (v >= va + vf && v < va + vf + vs) ? pol : !pol;
        e_fs = (t > 0) && (t % (ht * vt) == 0);
        check({name, ".hcount"},      32'(hc),  32'(h));
        check({name, ".vcount"},      32'(vc),  32'(v));
        check({name, ".hblnk"},       32'(hbl), 32'(h >= ha));
        check({name, ".vblnk"},       32'(vbl), 32'(v >= va));
        check({name, ".hsync"},       32'(hsy), 32'(e_hs));
        check({name, ".vsync"},       32'(vsy), 32'(e_vs));
        check({name, ".frame_start"}, 32'(fs),  32'(e_fs));
    endtask

    task automatic check_all(input longint t);
        check_dut("full", 800, 40, 128, 88, 600, 1, 4, 23, 1'b1, t,
                  f_hcount, f_vcount, f_hblnk, f_hsync, f_vblnk, f_vsync, f_fs);
        check_dut("small_n", SH_A, SH_F, SH_S, SH_B, SV_A, SV_F, SV_S, SV_B, 1'b0, t,
                  n_hcount, n_vcount, n_hblnk, n_hsync, n_vblnk, n_vsync, n_fs);
        check_dut("small_p", SH_A, SH_F, SH_S, SH_B, SV_A, SV_F, SV_S, SV_B, 1'b1, t,
                  p_hcount, p_vcount, p_hblnk, p_hsync, p_vblnk, p_vsync, p_fs);
    endtask

    // ---------------- drivers ----------------
    // Entered at a falling edge with reset held; releases it and runs.
    task automatic run_segment(input int n_cycles);
        t_cyc = 0;
        exp_q.delete();
        for (int k = 1; k * S_FRAME <= n_cycles; k++)
            exp_q.push_back(32'(k * S_FRAME));
        rst_n = 1'b1;
        repeat (n_cycles) begin
            @(posedge pclk);
            t_cyc++;
            @(negedge pclk);
            check_all(t_cyc);
            if (n_fs === 1'b1) begin
                if (exp_q.size() == 0)
                    check("small_n.fs_unexpected", 32'(t_cyc), 32'd0);
                else
                    check("small_n.fs_time", 32'(t_cyc), exp_q.pop_front());
            end
        end
        check("small_n.fs_missing", 32'(exp_q.size()), 32'd0);
    endtask

    // Reset lands between clock edges; outputs must clear with no edge.
    task automatic async_reset(input int hold);
        int d;
        d = $urandom_range(2, 10);
        @(posedge pclk);
        #(d);
        rst_n = 1'b0;
        t_cyc = 0;
        #1;
        check_all(0);
        repeat (hold) begin
            @(negedge pclk);
            check_all(0);
        end
    endtask

    // ---------------- sequence ----------------
    initial begin
        rst_n = 1'b0;
        repeat (3) begin
            @(negedge pclk);
            check_all(0);
        end
        // Long enough to cover the full-size line-5 wrap and many small frames.
        run_segment(8000);
        for (int i = 0; i < 3; i++) begin
            async_reset($urandom_range(1, 4));
            run_segment($urandom_range(300, 1500));
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
